// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner: buffers I-cache halfwords and presents one 16/32-bit instruction per cycle.
// Optional build macro ICACHE_BYTE_SWAP_EN byte-reverses each 32-bit lane of the fetch word.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FETCH_W  = 32,
    parameter int          BUF_HW   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              redirect_i,
    input  logic [31:0]                       redirect_pc_i,
    output logic                              icache_req_o,
    output logic [31-$clog2(FETCH_W/8):0]     icache_addr_o,
    input  logic [FETCH_W-1:0]                icache_data_i,
    input  logic                              icache_stall_i,
    output logic                              instr_valid_o,
    input  logic                              instr_ready_i,
    output logic [31:0]                       instr_o,
    output logic                              instr_c_o,
    output logic [31:0]                       instr_pc_o
);
    localparam int WB  = $clog2(FETCH_W/8);
    localparam int NHW = FETCH_W/16;
    localparam int PW  = $clog2(BUF_HW);

    typedef logic [PW:0]    ptr_t;
    typedef logic [PW-1:0]  idx_t;
    typedef logic [31-WB:0] faddr_t;

    localparam ptr_t FILL_MAX = ptr_t'(BUF_HW - NHW);

    logic [15:0]        hbuf [BUF_HW];
    ptr_t               wr_ptr, rd_ptr, count;
    faddr_t             fetch_addr;
    logic [WB-2:0]      drop;
    logic [31:0]        head_pc;
    logic [FETCH_W-1:0] fetch_data;
    logic [31:0]        tgt;
    logic [15:0]        h0, h1;
    logic               is_c, have, hit, pop;
    logic               unused_ok;

`ifdef ICACHE_BYTE_SWAP_EN
    always_comb begin
        fetch_data = '0;
        for (int l = 0; l < FETCH_W/32; l++) begin
            fetch_data[32*l +: 32] = {icache_data_i[32*l +: 8], icache_data_i[32*l+8 +: 8],
                                      icache_data_i[32*l+16 +: 8], icache_data_i[32*l+24 +: 8]};
        end
    end
`else
    assign fetch_data = icache_data_i;
`endif

    assign count = wr_ptr - rd_ptr;
    // Request only when a whole fetch word fits; a same-cycle pop earns no credit.
    assign icache_req_o  = !rst && !redirect_i && (count <= FILL_MAX);
    assign hit           = icache_req_o && !icache_stall_i;
    assign icache_addr_o = fetch_addr;

    assign h0   = hbuf[rd_ptr[PW-1:0]];
    assign h1   = hbuf[rd_ptr[PW-1:0] + idx_t'(1)];
    assign is_c = (h0[1:0] != 2'b11);
    assign have = is_c ? (count != '0) : (count >= ptr_t'(2));

    assign instr_valid_o = !rst && have;
    assign instr_o       = is_c ? {16'd0, h0} : {h1, h0};
    assign instr_c_o     = is_c;
    assign instr_pc_o    = rst ? RESET_PC : head_pc;
    assign pop           = instr_valid_o && instr_ready_i;

    // Reset is treated as a redirect to RESET_PC.
    assign tgt       = rst ? RESET_PC : redirect_pc_i;
    assign unused_ok = tgt[0];

    always_ff @(posedge clk) begin
        if (hit) begin
            for (int i = 0; i < NHW; i++) begin
                if (i >= int'(drop))
                    hbuf[idx_t'(wr_ptr) + idx_t'(i) - idx_t'(drop)] <= fetch_data[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_pc    <= {tgt[31:1], 1'b0};
            fetch_addr <= tgt[31:WB];
            drop       <= tgt[WB-1:1];
        end else begin
            if (hit) begin
                wr_ptr     <= wr_ptr + ptr_t'(NHW) - ptr_t'(drop);
                fetch_addr <= fetch_addr + faddr_t'(1);
                drop       <= '0;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + (is_c ? ptr_t'(1) : ptr_t'(2));
                head_pc <= head_pc + (is_c ? 32'd2 : 32'd4);
            end
        end
    end
endmodule

// File: tb/tb_fetch_aligner.sv
// Randomized bench for fetch_aligner: a memory-image model decodes the expected instruction stream
// from the head PC and tracks buffered halfwords as fetched-minus-consumed.
module tb_fetch_aligner;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int FETCH_W = 32;
    localparam int BUF_HW  = 8;
    localparam int WB      = $clog2(FETCH_W/8);
    localparam int NHW     = FETCH_W/16;
    localparam int LPW     = FETCH_W/32;

    logic                clk;
    logic                rst;
    logic                redirect_i;
    logic [31:0]         redirect_pc_i;
    logic                icache_req_o;
    logic [31-WB:0]      icache_addr_o;
    logic [FETCH_W-1:0]  icache_data_i;
    logic                icache_stall_i;
    logic                instr_valid_o;
    logic                instr_ready_i;
    logic [31:0]         instr_o;
    logic                instr_c_o;
    logic [31:0]         instr_pc_o;

    fetch_aligner #(.RESET_PC(RESET_PC), .FETCH_W(FETCH_W), .BUF_HW(BUF_HW)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .icache_req_o   (icache_req_o),
        .icache_addr_o  (icache_addr_o),
        .icache_data_i  (icache_data_i),
        .icache_stall_i (icache_stall_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .instr_c_o      (instr_c_o),
        .instr_pc_o     (instr_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    int          m_drop;
    int          m_avail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = mem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] lane(input logic [31:0] w);
`ifdef ICACHE_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [FETCH_W-1:0] fetch_word(input logic [31:0] waddr);
        logic [FETCH_W-1:0] d;
        logic [7:0] idx;
        d = '0;
        for (int k = 0; k < LPW; k++) begin
            idx = 8'(waddr * LPW + k);
            d[32*k +: 32] = lane(mem[idx]);
        end
        return d;
    endfunction

    task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit st, input bit rdy);
        logic [15:0] h;
        logic [31:0] exp_instr;
        logic [31:0] t;
        int len;
        bit exp_req, exp_valid;
        @(negedge clk);
        rst            = r;
        redirect_i     = rd;
        redirect_pc_i  = tgt;
        icache_stall_i = st;
        instr_ready_i  = rdy;
        icache_data_i  = fetch_word(m_fetch);
        #1;
        h         = hw_at(m_pc);
        len       = (h[1:0] == 2'b11) ? 2 : 1;
        exp_instr = (len == 2) ? {hw_at(m_pc + 32'd2), h} : {16'h0, h};
        exp_req   = !r && !rd && (BUF_HW - m_avail >= NHW);
        exp_valid = !r && (m_avail >= len);
        check_eq("req", icache_req_o, exp_req);
        check_eq("valid", instr_valid_o, exp_valid);
        if (r) begin
            check_eq("pc_in_reset", instr_pc_o, RESET_PC);
        end else begin
            check_eq("pc", instr_pc_o, m_pc);
            check_eq("addr", 32'(icache_addr_o), m_fetch);
        end
        if (exp_valid) begin
            check_eq("instr", instr_o, exp_instr);
            check_eq("instr_c", instr_c_o, len == 1);
        end
        if (r || rd) begin
            t       = r ? RESET_PC : tgt;
            m_pc    = {t[31:1], 1'b0};
            m_fetch = t >> WB;
            m_drop  = int'(t[WB-1:1]);
            m_avail = 0;
        end else begin
            if (exp_valid && rdy) begin
                m_pc    = m_pc + 32'(2 * len);
                m_avail = m_avail - len;
            end
            if (exp_req && !st) begin
                m_avail = m_avail + NHW - m_drop;
                m_fetch = m_fetch + 32'd1;
                m_drop  = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        icache_data_i = '0; icache_stall_i = 1'b0; instr_ready_i = 1'b0;
        m_pc = RESET_PC; m_fetch = RESET_PC >> WB; m_drop = 0; m_avail = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]    = 32'h00A0_0093;
        mem[1]    = {16'h4505, 16'h4501};
        mem[2]    = 32'h00B0_0113;
        mem[8'h40] = 32'h0093_4501;
        mem[8'h41] = 32'h0000_00A0;

        // reset, then addi / c.li / c.li / addi stream from address 0
        repeat (2) step(1, 0, '0, 0, 1);
        repeat (8) step(0, 0, '0, 0, 1);
        // redirect into the middle of a word with a straddling 32-bit instruction
        step(0, 1, 32'h102, 0, 1);
        repeat (6) step(0, 0, '0, 0, 1);
        // decode back-pressure: buffer fills, requests stop, nothing lost
        repeat (10) step(0, 0, '0, 0, 0);
        repeat (8) step(0, 0, '0, 0, 1);
        // stall in the middle of the straddle
        step(0, 1, 32'h102, 0, 1);
        step(0, 0, '0, 0, 1);
        repeat (5) step(0, 0, '0, 1, 1);
        repeat (4) step(0, 0, '0, 0, 1);
        // random mix of stalls, back-pressure, redirects (bit 0 random) and mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            step($urandom % 200 == 0, $urandom % 25 == 0, 32'($urandom_range(0, 1023)),
                 $urandom % 4 == 0, $urandom % 4 != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
